cpu_datapath: RTL and testbench

CPU_DATAPATH -- requirements
Module: cpu_datapath

---
 rtl/cpu_datapath_if.sv | 45 ++++
 rtl/cpu_datapath.sv | 198 +++++++++++++++++++
 tb/tb_cpu_datapath.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_datapath_if.sv
// Control, bus and observation signals of the CPU datapath, bundled for the
// datapath (slave) and whoever sequences it (master).
interface cpu_datapath_if;
  logic        HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin;
  logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Read, IncPC, write;
  logic [31:0] inportInput;
  logic [15:0] regIn;

  logic [31:0] busMuxOut;
  logic [4:0]  encoderOut;
  logic        CON;
  logic [31:0] BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3;
  logic [31:0] BusMuxInR4, BusMuxInR5, BusMuxInR6, BusMuxInR7;
  logic [31:0] BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11;
  logic [31:0] BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15;
  logic [31:0] BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR;
  logic [31:0] BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister;
  logic [8:0]  marToRam;

  modport master (
    output HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    output HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
    output Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
    input  busMuxOut, encoderOut, CON,
    input  BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5,
    input  BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
    input  BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
    input  BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR,
    input  BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister, marToRam
  );

  modport slave (
    input  HIin, LOin, PCin, MDRin, Zin, Yin, MARin, IRin, CONin, OUTPORTin,
    input  HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, OUTPORTout, Cout, Yout,
    input  Gra, Grb, Grc, Rin, Rout, BAout, Read, IncPC, write, inportInput, regIn,
    output busMuxOut, encoderOut, CON,
    output BusMuxInR0, BusMuxInR1, BusMuxInR2, BusMuxInR3, BusMuxInR4, BusMuxInR5,
    output BusMuxInR6, BusMuxInR7, BusMuxInR8, BusMuxInR9, BusMuxInR10, BusMuxInR11,
    output BusMuxInR12, BusMuxInR13, BusMuxInR14, BusMuxInR15,
    output BusMuxInHI, BusMuxInLO, BusMuxInZhi, BusMuxInZlo, BusMuxInPC, BusMuxInMDR,
    output BusMuxInInport, BusMuxInOutport, BusMuxInY, IRregister, Cregister, marToRam
  );
endinterface

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: register file, priority bus mux, ALU with 64-bit Z,
// branch condition flag and a 512x32 word RAM addressed by MAR.
module cpu_datapath (
  input logic           Clock,
  input logic           Clear,
  cpu_datapath_if.slave dp
);
  localparam int         NSRC     = 26;
  localparam logic [4:0] ENC_NONE = 5'd31;
  localparam logic [4:0] OP_SUB   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_OR    = 5'b00110;
  localparam logic [4:0] OP_SHR   = 5'b00111;
  localparam logic [4:0] OP_SHL   = 5'b01000;
  localparam logic [4:0] OP_MUL   = 5'b01110;
  localparam logic [4:0] OP_NEG   = 5'b01111;
  localparam logic [4:0] OP_NOT   = 5'b10000;

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] hi_q, hi_d, lo_q, lo_d, zhi_q, zhi_d, zlo_q, zlo_d;
  logic [31:0] pc_q, pc_d, mdr_q, mdr_d, inport_q, outport_q, outport_d;
  logic [31:0] y_q, y_d, ir_q, ir_d;
  logic [8:0]  mar_q, mar_d;
  logic        con_q, con_d;
  logic [31:0] ram [512];

  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [1:0]  c2;
  logic [31:0] c_sext;
  logic [15:0] sel;

  assign opcode = ir_q[31:27];
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign c2     = ir_q[20:19];
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};
  assign sel    = ({16{dp.Gra}} & (16'd1 << ra)) |
                  ({16{dp.Grb}} & (16'd1 << rb)) |
                  ({16{dp.Grc}} & (16'd1 << rc));

  function automatic logic [63:0] alu_eval(input logic [4:0] op,
                                           input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [63:0] prod;
    logic [31:0]        res;
    prod = 64'(a) * 64'(b);
    case (op)
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SHR:  res = $unsigned(a) >> b[4:0];
      OP_SHL:  res = $unsigned(a) << b[4:0];
      OP_MUL:  res = prod[31:0];
      OP_NEG:  res = -b;
      OP_NOT:  res = ~b;
      default: res = a + b;
    endcase
    return {(op == OP_MUL) ? prod[63:32] : 32'd0, res};
  endfunction

  function automatic logic con_eval(input logic [1:0] cond, input logic [31:0] v);
    case (cond)
      2'b00:   return v == 32'd0;
      2'b01:   return v != 32'd0;
      2'b10:   return !v[31];
      default: return v[31];
    endcase
  endfunction

  // Bus sources indexed by select code; BAout reads R0 as constant zero
  logic [31:0]     src [NSRC];
  logic [NSRC-1:0] req;
  logic [4:0]      enc;
  logic [31:0]     bus;

  always_comb begin
    for (int i = 0; i < 16; i++) src[i] = r_q[i];
    if (dp.BAout) src[0] = 32'd0;
    src[16] = hi_q;
    src[17] = lo_q;
    src[18] = zhi_q;
    src[19] = zlo_q;
    src[20] = pc_q;
    src[21] = mdr_q;
    src[22] = inport_q;
    src[23] = c_sext;
    src[24] = y_q;
    src[25] = outport_q;
  end

  assign req = {dp.OUTPORTout, dp.Yout, dp.Cout, dp.INPORTout, dp.MDRout, dp.PCout,
                dp.ZLOout, dp.ZHIout, dp.LOout, dp.HIout,
                sel & {16{dp.Rout | dp.BAout}}};

  always_comb begin
    enc = ENC_NONE;
    bus = 32'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        enc = 5'(i);
        bus = src[i];
      end
    end
  end

  logic [63:0] alu_res;
  assign alu_res = alu_eval(opcode, $signed(y_q), $signed(bus));

  always_comb begin
    for (int i = 0; i < 16; i++)
      r_d[i] = (dp.regIn[i] || (dp.Rin && sel[i])) ? bus : r_q[i];
    hi_d      = dp.HIin      ? bus : hi_q;
    lo_d      = dp.LOin      ? bus : lo_q;
    y_d       = dp.Yin       ? bus : y_q;
    ir_d      = dp.IRin      ? bus : ir_q;
    outport_d = dp.OUTPORTin ? bus : outport_q;
    mar_d     = dp.MARin     ? bus[8:0] : mar_q;
    zhi_d     = dp.Zin       ? alu_res[63:32] : zhi_q;
    zlo_d     = dp.Zin       ? alu_res[31:0]  : zlo_q;
    con_d     = dp.CONin     ? con_eval(c2, bus) : con_q;
    pc_d      = pc_q;
    if (dp.PCin) pc_d = dp.IncPC ? pc_q + 32'd1 : bus;
    mdr_d     = mdr_q;
    if (dp.MDRin) mdr_d = dp.Read ? ram[mar_q] : bus;
  end

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      for (int i = 0; i < 16; i++) r_q[i] <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      zhi_q     <= 32'd0;
      zlo_q     <= 32'd0;
      pc_q      <= 32'd0;
      mdr_q     <= 32'd0;
      inport_q  <= 32'd0;
      outport_q <= 32'd0;
      y_q       <= 32'd0;
      ir_q      <= 32'd0;
      mar_q     <= 9'd0;
      con_q     <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) r_q[i] <= r_d[i];
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zhi_q     <= zhi_d;
      zlo_q     <= zlo_d;
      pc_q      <= pc_d;
      mdr_q     <= mdr_d;
      inport_q  <= dp.inportInput;
      outport_q <= outport_d;
      y_q       <= y_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      con_q     <= con_d;
    end
  end

  // RAM keeps its contents across Clear; it relies on power-up zero initialisation
  always_ff @(posedge Clock) begin
    if (Clear && dp.write) ram[mar_q] <= mdr_q;
  end

  assign dp.busMuxOut       = bus;
  assign dp.encoderOut      = enc;
  assign dp.CON             = con_q;
  assign dp.BusMuxInR0      = r_q[0];
  assign dp.BusMuxInR1      = r_q[1];
  assign dp.BusMuxInR2      = r_q[2];
  assign dp.BusMuxInR3      = r_q[3];
  assign dp.BusMuxInR4      = r_q[4];
  assign dp.BusMuxInR5      = r_q[5];
  assign dp.BusMuxInR6      = r_q[6];
  assign dp.BusMuxInR7      = r_q[7];
  assign dp.BusMuxInR8      = r_q[8];
  assign dp.BusMuxInR9      = r_q[9];
  assign dp.BusMuxInR10     = r_q[10];
  assign dp.BusMuxInR11     = r_q[11];
  assign dp.BusMuxInR12     = r_q[12];
  assign dp.BusMuxInR13     = r_q[13];
  assign dp.BusMuxInR14     = r_q[14];
  assign dp.BusMuxInR15     = r_q[15];
  assign dp.BusMuxInHI      = hi_q;
  assign dp.BusMuxInLO      = lo_q;
  assign dp.BusMuxInZhi     = zhi_q;
  assign dp.BusMuxInZlo     = zlo_q;
  assign dp.BusMuxInPC      = pc_q;
  assign dp.BusMuxInMDR     = mdr_q;
  assign dp.BusMuxInInport  = inport_q;
  assign dp.BusMuxInOutport = outport_q;
  assign dp.BusMuxInY       = y_q;
  assign dp.IRregister      = ir_q;
  assign dp.Cregister       = c_sext;
  assign dp.marToRam        = mar_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios plus randomized
// bus-priority and ALU traffic checked against a register-level model.
module tb_cpu_datapath;
  logic Clock = 1'b0;
  logic Clear = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  cpu_datapath_if dp();
  cpu_datapath dut (.Clock(Clock), .Clear(Clear), .dp(dp));

  always #5 Clock = ~Clock;

  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mdr, m_in, m_out, m_y, m_ir;

  task automatic set_all(input logic v);
    dp.HIin = v; dp.LOin = v; dp.PCin = v; dp.MDRin = v; dp.Zin = v;
    dp.Yin = v; dp.MARin = v; dp.IRin = v; dp.CONin = v; dp.OUTPORTin = v;
    dp.HIout = v; dp.LOout = v; dp.ZHIout = v; dp.ZLOout = v; dp.PCout = v;
    dp.MDRout = v; dp.INPORTout = v; dp.OUTPORTout = v; dp.Cout = v; dp.Yout = v;
    dp.Gra = v; dp.Grb = v; dp.Grc = v; dp.Rin = v; dp.Rout = v; dp.BAout = v;
    dp.Read = v; dp.IncPC = v; dp.write = v;
    dp.regIn = {16{v}};
  endtask

  task automatic idle();
    set_all(1'b0);
  endtask

  // One clock edge; the input port is captured on every edge
  task automatic step();
    @(posedge Clock);
    m_in = Clear ? dp.inportInput : 32'd0;
    #1;
  endtask

  function automatic logic [31:0] get_r(input int i);
    case (i)
      0: return dp.BusMuxInR0;   1: return dp.BusMuxInR1;   2: return dp.BusMuxInR2;
      3: return dp.BusMuxInR3;   4: return dp.BusMuxInR4;   5: return dp.BusMuxInR5;
      6: return dp.BusMuxInR6;   7: return dp.BusMuxInR7;   8: return dp.BusMuxInR8;
      9: return dp.BusMuxInR9;   10: return dp.BusMuxInR10; 11: return dp.BusMuxInR11;
      12: return dp.BusMuxInR12; 13: return dp.BusMuxInR13; 14: return dp.BusMuxInR14;
      default: return dp.BusMuxInR15;
    endcase
  endfunction

  function automatic logic [31:0] sext19(input logic [31:0] w);
    return {{13{w[18]}}, w[18:0]};
  endfunction

  // Model value of each bus source by its select code
  function automatic logic [31:0] mval(input int code);
    if (code < 16) return m_r[code];
    case (code)
      16: return m_hi;  17: return m_lo;  18: return m_zhi; 19: return m_zlo;
      20: return m_pc;  21: return m_mdr; 22: return m_in;  23: return sext19(m_ir);
      24: return m_y;   default: return m_out;
    endcase
  endfunction

  // Put v on the bus via the input port and load target tgt
  // (0-15 Rn via regIn, 16 HI, 17 LO, 20 PC, 21 MDR, 24 Y, 25 Outport, 26 IR, 27 MAR)
  task automatic bus_load(input logic [31:0] v, input int tgt);
    idle();
    dp.inportInput = v;
    step();
    dp.INPORTout = 1'b1;
    case (tgt)
      16: begin dp.HIin = 1'b1;      m_hi  = v; end
      17: begin dp.LOin = 1'b1;      m_lo  = v; end
      20: begin dp.PCin = 1'b1;      m_pc  = v; end
      21: begin dp.MDRin = 1'b1;     m_mdr = v; end
      24: begin dp.Yin = 1'b1;       m_y   = v; end
      25: begin dp.OUTPORTin = 1'b1; m_out = v; end
      26: begin dp.IRin = 1'b1;      m_ir  = v; end
      27: dp.MARin = 1'b1;
      default: begin dp.regIn = 16'd1 << tgt; m_r[tgt] = v; end
    endcase
    step();
    idle();
  endtask

  task automatic test_reset();
    logic [31:0] v [27];
    set_all(1'b1);
    dp.inportInput = $urandom;
    Clear = 1'b0;
    step();
    for (int i = 0; i < 16; i++) v[i] = get_r(i);
    v[16] = dp.BusMuxInHI;  v[17] = dp.BusMuxInLO;  v[18] = dp.BusMuxInZhi;
    v[19] = dp.BusMuxInZlo; v[20] = dp.BusMuxInPC;  v[21] = dp.BusMuxInMDR;
    v[22] = dp.BusMuxInInport; v[23] = dp.BusMuxInOutport; v[24] = dp.BusMuxInY;
    v[25] = dp.IRregister;  v[26] = dp.Cregister;
    for (int i = 0; i < 27; i++) begin
      n_checks++;
      if (v[i] !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg[%0d]: got %h expected 0", i, v[i]);
      end
    end
    n_checks++;
    if (dp.CON !== 1'b0) begin n_fail++; $display("FAIL reset_con: got %b expected 0", dp.CON); end
    n_checks++;
    if (dp.marToRam !== 9'd0) begin n_fail++; $display("FAIL reset_mar: got %h expected 0", dp.marToRam); end
    // all requests on: R0 (selected by zeroed IR) wins and BAout forces zero
    n_checks++;
    if (dp.encoderOut !== 5'd0 || dp.busMuxOut !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus_all: got enc %0d bus %h expected enc 0 bus 0", dp.encoderOut, dp.busMuxOut);
    end
    idle();
    Clear = 1'b1;
    #1;
    n_checks++;
    if (dp.encoderOut !== 5'd31 || dp.busMuxOut !== 32'd0) begin
      n_fail++; $display("FAIL idle_bus: got enc %0d bus %h expected enc 31 bus 0", dp.encoderOut, dp.busMuxOut);
    end
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_hi = 0; m_lo = 0; m_zhi = 0; m_zlo = 0; m_pc = 0; m_mdr = 0; m_out = 0; m_y = 0; m_ir = 0;
  endtask

  task automatic test_inport_pc();
    idle();
    dp.inportInput = 32'd11;
    step();
    dp.INPORTout = 1'b1; dp.PCin = 1'b1;
    #1;
    n_checks++;
    if (dp.encoderOut !== 5'd22 || dp.busMuxOut !== 32'd11) begin
      n_fail++; $display("FAIL inport_bus: got enc %0d bus %h expected enc 22 bus b", dp.encoderOut, dp.busMuxOut);
    end
    step();
    idle();
    m_pc = 32'd11;
    n_checks++;
    if (dp.BusMuxInPC !== 32'd11) begin n_fail++; $display("FAIL inport_pc: got %h expected b", dp.BusMuxInPC); end
  endtask

  task automatic test_pc_inc();
    bus_load(32'd5, 20);
    dp.IncPC = 1'b1;
    step();
    n_checks++;
    if (dp.BusMuxInPC !== 32'd5) begin n_fail++; $display("FAIL incpc_alone: got %h expected 5", dp.BusMuxInPC); end
    dp.PCin = 1'b1;
    step();
    n_checks++;
    if (dp.BusMuxInPC !== 32'd6) begin n_fail++; $display("FAIL pc_inc: got %h expected 6", dp.BusMuxInPC); end
    bus_load(32'hFFFF_FFFF, 20);
    dp.PCin = 1'b1; dp.IncPC = 1'b1;
    step();
    idle();
    m_pc = 32'd0;
    n_checks++;
    if (dp.BusMuxInPC !== 32'd0) begin n_fail++; $display("FAIL pc_wrap: got %h expected 0", dp.BusMuxInPC); end
  endtask

  task automatic test_memory();
    bus_load(32'd11, 27);
    bus_load(32'h9310_0019, 21);
    n_checks++;
    if (dp.marToRam !== 9'd11 || dp.BusMuxInMDR !== 32'h9310_0019) begin
      n_fail++; $display("FAIL mem_setup: got mar %0d mdr %h expected 11 93100019", dp.marToRam, dp.BusMuxInMDR);
    end
    dp.write = 1'b1;
    step();
    idle();
    dp.MDRin = 1'b1;
    step();
    n_checks++;
    if (dp.BusMuxInMDR !== 32'd0) begin n_fail++; $display("FAIL mdr_clear: got %h expected 0", dp.BusMuxInMDR); end
    dp.Read = 1'b1;
    step();
    idle();
    m_mdr = 32'h9310_0019;
    n_checks++;
    if (dp.BusMuxInMDR !== 32'h9310_0019) begin
      n_fail++; $display("FAIL mem_read: got %h expected 93100019", dp.BusMuxInMDR);
    end
  endtask

  task automatic test_brpl(input logic [31:0] r6, input logic [31:0] irw);
    logic        exp_con;
    logic [31:0] exp_z;
    case (irw[20:19])
      2'b00: exp_con = (r6 == 32'd0);
      2'b01: exp_con = (r6 != 32'd0);
      2'b10: exp_con = (r6[31] == 1'b0);
      default: exp_con = (r6[31] == 1'b1);
    endcase
    exp_z = 32'd12 + sext19(irw);
    bus_load(r6, 6);
    bus_load(32'd11, 27);
    bus_load(irw, 21);
    dp.write = 1'b1; step(); idle();
    bus_load(32'd11, 20);
    dp.PCout = 1'b1; dp.MARin = 1'b1; step(); idle();
    dp.Read = 1'b1; dp.MDRin = 1'b1; dp.PCin = 1'b1; dp.IncPC = 1'b1; step(); idle();
    n_checks++;
    if (dp.BusMuxInPC !== 32'd12 || dp.BusMuxInMDR !== irw) begin
      n_fail++; $display("FAIL brpl_t1: got pc %h mdr %h expected c %h", dp.BusMuxInPC, dp.BusMuxInMDR, irw);
    end
    dp.MDRout = 1'b1; dp.IRin = 1'b1; step(); idle();
    n_checks++;
    if (dp.IRregister !== irw || dp.Cregister !== sext19(irw)) begin
      n_fail++; $display("FAIL brpl_ir: got ir %h c %h expected %h %h", dp.IRregister, dp.Cregister, irw, sext19(irw));
    end
    dp.Gra = 1'b1; dp.Rout = 1'b1; dp.CONin = 1'b1;
    #1;
    n_checks++;
    if (dp.encoderOut !== 5'd6 || dp.busMuxOut !== r6) begin
      n_fail++; $display("FAIL brpl_gra: got enc %0d bus %h expected 6 %h", dp.encoderOut, dp.busMuxOut, r6);
    end
    step(); idle();
    n_checks++;
    if (dp.CON !== exp_con) begin n_fail++; $display("FAIL brpl_con: got %b expected %b", dp.CON, exp_con); end
    dp.PCout = 1'b1; dp.Yin = 1'b1; step(); idle();
    dp.Cout = 1'b1; dp.Zin = 1'b1; step(); idle();
    n_checks++;
    if (dp.BusMuxInZlo !== exp_z || dp.BusMuxInZhi !== 32'd0) begin
      n_fail++; $display("FAIL brpl_z: got %h:%h expected 0:%h", dp.BusMuxInZhi, dp.BusMuxInZlo, exp_z);
    end
    dp.ZLOout = 1'b1; dp.PCin = 1'b1; step(); idle();
    n_checks++;
    if (dp.BusMuxInPC !== exp_z) begin n_fail++; $display("FAIL brpl_pc: got %h expected %h", dp.BusMuxInPC, exp_z); end
    m_mdr = irw; m_ir = irw; m_y = 32'd12; m_zhi = 32'd0; m_zlo = exp_z; m_pc = exp_z;
  endtask

  task automatic test_alu();
    logic [4:0]  ops [9];
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp_z;
    ops = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01110, 5'b01111, 5'b10000, 5'b00011};
    for (int k = 0; k < 24; k++) begin
      if (k == 0) begin op = 5'b00100; a = 32'd7; b = 32'd5; end
      else if (k == 1) begin op = 5'b01110; a = -32'sd3; b = 32'd4; end
      else begin
        op = (k % 4 == 3) ? 5'($urandom) : ops[$urandom_range(0, 8)];
        a = $urandom; b = $urandom;
      end
      case (op)
        5'b00100: exp_z = {32'd0, a - b};
        5'b00101: exp_z = {32'd0, a & b};
        5'b00110: exp_z = {32'd0, a | b};
        5'b00111: exp_z = {32'd0, a >> b[4:0]};
        5'b01000: exp_z = {32'd0, a << b[4:0]};
        5'b01110: exp_z = 64'(longint'(int'(a)) * longint'(int'(b)));
        5'b01111: exp_z = {32'd0, 32'd0 - b};
        5'b10000: exp_z = {32'd0, ~b};
        default:  exp_z = {32'd0, a + b};
      endcase
      bus_load({op, 27'd0}, 26);
      bus_load(a, 24);
      dp.inportInput = b;
      step();
      dp.INPORTout = 1'b1; dp.Zin = 1'b1;
      step();
      idle();
      m_zhi = exp_z[63:32]; m_zlo = exp_z[31:0];
      n_checks++;
      if (dp.BusMuxInZhi !== exp_z[63:32] || dp.BusMuxInZlo !== exp_z[31:0]) begin
        n_fail++;
        $display("FAIL alu op=%b a=%h b=%h: got %h:%h expected %h", op, a, b, dp.BusMuxInZhi, dp.BusMuxInZlo, exp_z);
      end
    end
  endtask

  task automatic test_select();
    logic [31:0] v;
    v = $urandom | 32'd1;
    bus_load({5'd0, 4'd0, 4'd9, 19'($urandom)}, 26);
    bus_load(v, 0);
    dp.Gra = 1'b1; dp.BAout = 1'b1;
    #1;
    n_checks++;
    if (dp.encoderOut !== 5'd0 || dp.busMuxOut !== 32'd0) begin
      n_fail++; $display("FAIL baout_r0: got enc %0d bus %h expected 0 0", dp.encoderOut, dp.busMuxOut);
    end
    dp.BAout = 1'b0; dp.Rout = 1'b1;
    #1;
    n_checks++;
    if (dp.busMuxOut !== v) begin n_fail++; $display("FAIL rout_r0: got %h expected %h", dp.busMuxOut, v); end
    // Rin with Grb loads the register named by Rb (R9)
    idle();
    v = $urandom;
    dp.inportInput = v;
    step();
    dp.INPORTout = 1'b1; dp.Grb = 1'b1; dp.Rin = 1'b1;
    step();
    idle();
    m_r[9] = v;
    n_checks++;
    if (dp.BusMuxInR9 !== v) begin n_fail++; $display("FAIL rin_grb: got %h expected %h", dp.BusMuxInR9, v); end
    bus_load({5'd0, 4'd9, 23'($urandom)}, 26);
    dp.Gra = 1'b1; dp.BAout = 1'b1;
    #1;
    n_checks++;
    if (dp.encoderOut !== 5'd9 || dp.busMuxOut !== m_r[9]) begin
      n_fail++; $display("FAIL baout_r9: got enc %0d bus %h expected 9 %h", dp.encoderOut, dp.busMuxOut, m_r[9]);
    end
    idle();
  endtask

  task automatic test_bus_priority();
    logic [9:0]  o;
    logic [2:0]  g;
    logic        ro, found, want;
    logic [4:0]  exp_enc;
    logic [31:0] exp_bus;
    bus_load($urandom, 26);
    for (int i = 0; i < 16; i++) bus_load($urandom, i);
    bus_load($urandom, 16);
    bus_load($urandom, 17);
    bus_load($urandom, 20);
    bus_load($urandom, 21);
    bus_load($urandom, 24);
    bus_load($urandom, 25);
    bus_load($urandom, 27);
    for (int t = 0; t < 40; t++) begin
      o  = 10'($urandom) & 10'($urandom) & 10'($urandom);
      g  = 3'($urandom);
      ro = 1'($urandom);
      idle();
      dp.HIout = o[0]; dp.LOout = o[1]; dp.ZHIout = o[2]; dp.ZLOout = o[3]; dp.PCout = o[4];
      dp.MDRout = o[5]; dp.INPORTout = o[6]; dp.Cout = o[7]; dp.Yout = o[8]; dp.OUTPORTout = o[9];
      dp.Gra = g[0]; dp.Grb = g[1]; dp.Grc = g[2]; dp.Rout = ro;
      found = 1'b0; exp_enc = 5'd31; exp_bus = 32'd0;
      for (int c = 0; c < 26; c++) begin
        if (c < 16) want = ro && ((g[0] && m_ir[26:23] == c) || (g[1] && m_ir[22:19] == c) ||
                                  (g[2] && m_ir[18:15] == c));
        else        want = o[c - 16];
        if (want && !found) begin
          found = 1'b1; exp_enc = 5'(c); exp_bus = mval(c);
        end
      end
      #1;
      n_checks++;
      if (dp.encoderOut !== exp_enc || dp.busMuxOut !== exp_bus) begin
        n_fail++;
        $display("FAIL bus_prio o=%b g=%b rout=%b: got enc %0d bus %h expected enc %0d bus %h",
                 o, g, ro, dp.encoderOut, dp.busMuxOut, exp_enc, exp_bus);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    dp.inportInput = 32'd0;
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    test_reset();
    test_inport_pc();
    test_pc_inc();
    test_memory();
    test_brpl(32'd0, 32'h9310_0019);
    test_brpl(32'h8000_0000, 32'h9310_0019);
    test_brpl(32'h8000_0000, 32'h9318_0019);
    for (int k = 0; k < 6; k++)
      test_brpl(($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                {5'b10010, 4'd6, 4'($urandom), 19'($urandom)});
    test_alu();
    test_select();
    test_bus_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
